// File: rtl/mfp_clock_mode_ctrl_pkg.sv
// Shared definitions for the clock-mode controller: FSM state codes and the
// mode select codes understood by the system clock block.
package mfp_clock_mode_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    localparam logic [1:0] MODE_REF       = 2'd0;
    localparam logic [1:0] MODE_PLL_LOW   = 2'd1;
    localparam logic [1:0] MODE_PLL_HIGH  = 2'd2;
    localparam logic [1:0] MODE_BYPASS    = 2'd3;

endpackage

// File: rtl/mfp_sync_bit.sv
// N-stage single-bit synchronizer with asynchronous active-low reset.
module mfp_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/mfp_clock_mode_ctrl.sv
// Clock-mode controller: drives the clock block mode select and sequences the
// CPU-domain reset around mode changes and loss of lock.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_HOLD      | sys_resetn low, counting reset-hold cycles before mode moves
// ST_WAIT_LOCK | sys_resetn low, counting consecutive synchronized-lock cycles
// ST_RUN       | sys_resetn high, requests accepted while lock is held
module mfp_clock_mode_ctrl
    import mfp_clock_mode_ctrl_pkg::*;
#(
    parameter int         LOCK_SYNC_STAGES   = 2,
    parameter int         LOCK_STABLE_CYCLES = 16,
    parameter int         RESET_HOLD_CYCLES  = 8,
    parameter logic [1:0] DEFAULT_MODE       = MODE_REF,
    parameter int         CNT_W              = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       locked,
    input  logic       req_valid,
    input  logic [1:0] req_mode,
    output logic       req_ready,
    output logic [1:0] mode,
    output logic       sys_resetn,
    output logic       busy,
    output logic       lock_lost
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

    logic             locked_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [1:0]       pend_q, pend_d;
    logic             sys_resetn_q, sys_resetn_d;
    logic             lock_lost_q, lock_lost_d;

    mfp_sync_bit #(
        .STAGES (LOCK_SYNC_STAGES)
    ) u_lock_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (locked),
        .q      (locked_s)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_WAIT_LOCK;
            cnt_q        <= '0;
            mode_q       <= DEFAULT_MODE;
            pend_q       <= DEFAULT_MODE;
            sys_resetn_q <= 1'b0;
            lock_lost_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            pend_q       <= pend_d;
            sys_resetn_q <= sys_resetn_d;
            lock_lost_q  <= lock_lost_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        pend_d       = pend_q;
        sys_resetn_d = sys_resetn_q;
        lock_lost_d  = 1'b0;

        unique case (state_q)
            ST_WAIT_LOCK: begin
                // Any unlocked cycle restarts the stability window.
                if (!locked_s) begin
                    cnt_d = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    sys_resetn_d = 1'b1;
                    state_d      = ST_RUN;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    sys_resetn_d = 1'b0;
                    lock_lost_d  = 1'b1;
                    state_d      = ST_WAIT_LOCK;
                    cnt_d        = '0;
                end else if (req_valid) begin
                    pend_d       = req_mode;
                    sys_resetn_d = 1'b0;
                    state_d      = ST_HOLD;
                    cnt_d        = '0;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    mode_d  = pend_q;
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                sys_resetn_d = 1'b0;
                state_d      = ST_WAIT_LOCK;
                cnt_d        = '0;
            end
        endcase
    end

    assign req_ready  = (state_q == ST_RUN) && locked_s;
    assign busy       = (state_q != ST_RUN);
    assign mode       = mode_q;
    assign sys_resetn = sys_resetn_q;
    assign lock_lost  = lock_lost_q;

endmodule
